// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller: FSM state encoding,
// mul/div countdown width and the helper that derives the countdown reload.
package hazard_stall_ctrl_pkg;

  // Two-state controller: normal issue, or EX occupied by a multi-cycle mul/div
  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_MD_BUSY = 1'b1
  } hz_state_e;

  // The countdown only needs to cover MD_LATENCY up to 16
  localparam int MD_CNT_W = 4;

  // The issue cycle and the md_done cycle are not counted down, so the
  // countdown starts two below the total EX latency.
  function automatic logic [MD_CNT_W-1:0] md_reload(input int latency);
    return MD_CNT_W'(latency - 2);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_loaduse_cmp.sv
// Combinational load-use detector: the load in EX writes a register the
// instruction in ID actually reads, and that register is not x0.
module hazard_loaduse_cmp
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic             i_use_rs1,
  input  logic             i_use_rs2,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rd,
  output logic             o_load_use
);

  logic w_rd_nonzero;
  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_rd_nonzero = (i_ex_rd != '0);
  assign w_hit_rs1    = i_use_rs1 && (i_rs1 == i_ex_rd);
  assign w_hit_rs2    = i_use_rs2 && (i_rs2 == i_ex_rd);
  assign o_load_use   = i_ex_mem_read && w_rd_nonzero && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller beside the ID/EX stage. Stalls IF/ID for one
// cycle on load-use, freezes IF..EX while a mul/div occupies EX, flushes
// wrong-path instructions on an EX redirect, and counts stalled cycles.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_rs1,
  input  logic [REG_W-1:0] ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_rd,
  input  logic             EX_md_start,
  input  logic             EX_redirect,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [MD_CNT_W-1:0] MD_RELOAD = md_reload(MD_LATENCY);

  hz_state_e           r_state;
  hz_state_e           w_next_state;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [MD_CNT_W-1:0] w_md_cnt_next;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic w_load_use;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_idex_write;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_exmem_flush;
  logic w_md_done;

  hazard_loaduse_cmp #(
    .REG_W(REG_W)
  ) u_loaduse_cmp (
    .i_rs1        (ID_rs1),
    .i_rs2        (ID_rs2),
    .i_use_rs1    (ID_use_rs1),
    .i_use_rs2    (ID_use_rs2),
    .i_ex_mem_read(EX_MemRead),
    .i_ex_rd      (EX_rd),
    .o_load_use   (w_load_use)
  );

  // Next-state and control decode; reset forces the safe "hold and flush everything" pattern
  always_comb begin
    w_next_state  = r_state;
    w_md_cnt_next = r_md_cnt;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_idex_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_md_done     = 1'b0;

    case (r_state)
      HZ_RUN: begin
        if (EX_redirect) begin
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
        end else if (EX_md_start) begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_write  = 1'b0;
          w_exmem_flush = 1'b1;
          w_md_cnt_next = MD_RELOAD;
          w_next_state  = HZ_MD_BUSY;
        end else if (w_load_use) begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_idex_flush = 1'b1;
        end
      end
      HZ_MD_BUSY: begin
        if (r_md_cnt != '0) begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_write  = 1'b0;
          w_exmem_flush = 1'b1;
          w_md_cnt_next = r_md_cnt - 1'b1;
        end else begin
          w_md_done    = 1'b1;
          w_next_state = HZ_RUN;
        end
      end
      default: begin
        w_next_state  = HZ_RUN;
        w_md_cnt_next = '0;
      end
    endcase

    if (rst) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_write  = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
      w_md_done     = 1'b0;
    end
  end

  // FSM state and mul/div countdown; reset aborts any mul/div in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= HZ_RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_next_state;
      r_md_cnt <= w_md_cnt_next;
    end
  end

  // Performance counter of cycles in which the PC did not advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_write) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign PC_Write    = w_pc_write;
  assign IFID_Write  = w_ifid_write;
  assign IDEX_Write  = w_idex_write;
  assign IFID_Flush  = w_ifid_flush;
  assign IDEX_Flush  = w_idex_flush;
  assign EXMEM_Flush = w_exmem_flush;
  assign md_done     = w_md_done;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: the stimulus side predicts each
// cycle's controls from the pipeline rules and queues them; a monitor on
// the falling edge pops and compares against the DUT.
module tb_hazard_stall_ctrl;

  localparam int REG_W      = 5;
  localparam int MD_LATENCY = 4;
  localparam int CNT_W      = 32;

  // Expected control vector order: PC_Write, IFID_Write, IDEX_Write,
  // IFID_Flush, IDEX_Flush, EXMEM_Flush, md_done
  localparam logic [6:0] CTL_RESET  = 7'b000_111_0;
  localparam logic [6:0] CTL_NORMAL = 7'b111_000_0;
  localparam logic [6:0] CTL_FREEZE = 7'b000_001_0;
  localparam logic [6:0] CTL_DONE   = 7'b111_000_1;
  localparam logic [6:0] CTL_REDIR  = 7'b111_110_0;
  localparam logic [6:0] CTL_LDUSE  = 7'b001_010_0;

  typedef struct {
    logic [6:0]       ctl;
    logic [CNT_W-1:0] cnt;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [REG_W-1:0] ID_rs1 = '0;
  logic [REG_W-1:0] ID_rs2 = '0;
  logic             ID_use_rs1 = 1'b0;
  logic             ID_use_rs2 = 1'b0;
  logic             EX_MemRead = 1'b0;
  logic [REG_W-1:0] EX_rd = '0;
  logic             EX_md_start = 1'b0;
  logic             EX_redirect = 1'b0;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IDEX_Write;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             EXMEM_Flush;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;

  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: whether a mul/div occupies EX and the absolute
  // cycle on which its result is due, plus the running stall total.
  bit               mdActive = 1'b0;
  int               mdDoneCycle = 0;
  int               cycleNum = 0;
  logic [CNT_W-1:0] modelStall = '0;

  hazard_stall_ctrl #(
    .REG_W(REG_W),
    .MD_LATENCY(MD_LATENCY),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ID_rs1     (ID_rs1),
    .ID_rs2     (ID_rs2),
    .ID_use_rs1 (ID_use_rs1),
    .ID_use_rs2 (ID_use_rs2),
    .EX_MemRead (EX_MemRead),
    .EX_rd      (EX_rd),
    .EX_md_start(EX_md_start),
    .EX_redirect(EX_redirect),
    .PC_Write   (PC_Write),
    .IFID_Write (IFID_Write),
    .IDEX_Write (IDEX_Write),
    .IFID_Flush (IFID_Flush),
    .IDEX_Flush (IDEX_Flush),
    .EXMEM_Flush(EXMEM_Flush),
    .md_done    (md_done),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, optionally pulse reset mid-cycle, and queue the predicted response
  task automatic applyStimulus(input bit doReset, input bit memRead, input logic [REG_W-1:0] exRd,
                               input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                               input bit use1, input bit use2, input bit mdStart, input bit redirect);
    exp_t e;
    bit   loadUse;
    @(posedge clk);
    #1;
    EX_MemRead  = memRead;
    EX_rd       = exRd;
    ID_rs1      = rs1;
    ID_rs2      = rs2;
    ID_use_rs1  = use1;
    ID_use_rs2  = use2;
    EX_md_start = mdStart;
    EX_redirect = redirect;
    if (!doReset) rst = 1'b0;
    cycleNum++;
    if (doReset) begin
      #2;
      rst        = 1'b1;
      mdActive   = 1'b0;
      modelStall = '0;
      e.ctl      = CTL_RESET;
      e.cnt      = '0;
    end else begin
      e.cnt   = modelStall;
      e.ctl   = CTL_NORMAL;
      loadUse = memRead && (exRd != 0) && ((use1 && rs1 == exRd) || (use2 && rs2 == exRd));
      if (mdActive) begin
        if (cycleNum < mdDoneCycle) begin
          e.ctl = CTL_FREEZE;
        end else begin
          e.ctl    = CTL_DONE;
          mdActive = 1'b0;
        end
      end else if (redirect) begin
        e.ctl = CTL_REDIR;
      end else if (mdStart) begin
        e.ctl       = CTL_FREEZE;
        mdActive    = 1'b1;
        mdDoneCycle = cycleNum + MD_LATENCY - 1;
      end else if (loadUse) begin
        e.ctl = CTL_LDUSE;
      end
      if (!e.ctl[6]) modelStall = modelStall + 1'b1;
    end
    e.cyc = cycleNum;
    scoreboard.push_back(e);
  endtask

  // Compare one queued prediction against what the DUT is presenting now
  task automatic checkOutput(input exp_t e);
    logic [6:0] act;
    act = {PC_Write, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, md_done};
    checks++;
    if (act !== e.ctl) begin
      errors++;
      $display("[TB] FAIL controls cycle %0d: got %b expected %b", e.cyc, act, e.ctl);
    end
    checks++;
    if (stall_cnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL stall_cnt cycle %0d: got %0d expected %0d", e.cyc, stall_cnt, e.cnt);
    end
  endtask

  // Monitor: on every falling edge, check the oldest outstanding prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput(e);
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    // reset asserted asynchronously mid-cycle
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // load-use on rs2, then a clean cycle showing the count
    applyStimulus(0, 1, 5, 0, 5, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // x0 destination never stalls
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, 0);

    // mul/div held through its freeze, then released
    for (int i = 0; i < MD_LATENCY; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // redirect outranks md_start and load-use
    applyStimulus(0, 1, 5, 5, 0, 1, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset in the middle of a mul/div, then a fresh full sequence
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < MD_LATENCY; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // randomized mix with small register indices to force collisions
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 1) == 1),
                    REG_W'($urandom_range(0, 3)),
                    REG_W'($urandom_range(0, 3)),
                    REG_W'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(negedge clk);
    if (scoreboard.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0", scoreboard.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
